// File: rtl/int_isq_agemat.sv
// Integer issue queue: DEPTH entries, NUM_WB writeback wakeup ports, age-matrix oldest-ready select, ROB-id flush.
// Optional feature macro ISQ_WB_BYPASS_EN: same-cycle writeback hits count toward issue eligibility.
module int_isq_agemat #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned PREG_W  = 6,
    parameter int unsigned ROBID_W = 6,
    parameter int unsigned NUM_WB  = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [DATA_W-1:0]          enq_data,
    input  logic [PREG_W-1:0]          enq_prs1,
    input  logic [PREG_W-1:0]          enq_prs2,
    input  logic [1:0]                 enq_src_rdy,
    input  logic [ROBID_W:0]           enq_robid,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [DATA_W-1:0]          deq_data,
    output logic [ROBID_W:0]           deq_robid,
    output logic [$clog2(DEPTH)-1:0]   deq_index,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*PREG_W-1:0]   wb_prd,
    input  logic                       flush_valid,
    input  logic [ROBID_W:0]           flush_robid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned RID_W = ROBID_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [RID_W-1:0]  robid;
        logic [PREG_W-1:0] prs1;
        logic [PREG_W-1:0] prs2;
    } ent_t;

    // Entry state; age_q[i][j]=1 means entry i is older than entry j.
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] age_q [DEPTH];
    ent_t             ent_q [DEPTH];
    logic [1:0]       rdy_q [DEPTH];
    logic [CNT_W-1:0] count_q;

    logic [1:0]       wake [DEPTH];
    logic [1:0]       enq_wake;
    logic [DEPTH-1:0] elig;
    logic [DEPTH-1:0] sel_oh;
    logic [DEPTH-1:0] valid_d;
    logic [CNT_W-1:0] count_d;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] free_idx;
    logic             free_found;
    logic             any_elig;
    logic             enq_fire;
    logic             deq_fire;

    // Wrap-aware ROB ordering: a is younger than b.
    function automatic logic younger(input logic [RID_W-1:0] a, input logic [RID_W-1:0] b);
        if (a[RID_W-1] != b[RID_W-1]) begin
            return a[RID_W-2:0] < b[RID_W-2:0];
        end
        return a[RID_W-2:0] > b[RID_W-2:0];
    endfunction

    function automatic logic wb_match(input logic [PREG_W-1:0]        preg,
                                      input logic [NUM_WB-1:0]        vld,
                                      input logic [NUM_WB*PREG_W-1:0] prd);
        logic hit;
        hit = 1'b0;
        for (int unsigned p = 0; p < NUM_WB; p++) begin
            if (vld[p] && (prd[p*PREG_W +: PREG_W] == preg)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Writeback tag match for every stored source and for the incoming entry.
    always_comb begin
        enq_wake = {wb_match(enq_prs1, wb_valid, wb_prd), wb_match(enq_prs2, wb_valid, wb_prd)};
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wake[i] = {wb_match(ent_q[i].prs1, wb_valid, wb_prd),
                       wb_match(ent_q[i].prs2, wb_valid, wb_prd)};
        end
    end

    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef ISQ_WB_BYPASS_EN
            elig[i] = valid_q[i] && ((rdy_q[i] | wake[i]) == 2'b11);
`else
            elig[i] = valid_q[i] && (rdy_q[i] == 2'b11);
`endif
        end
    end

    // Oldest eligible entry: no other eligible entry is older than it.
    always_comb begin
        sel_oh  = '0;
        sel_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            sel_oh[i] = elig[i];
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (elig[j] && age_q[j][i]) begin
                    sel_oh[i] = 1'b0;
                end
            end
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    // Lowest-index free slot, judged on the current-cycle valids only.
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
        end
    end

    assign any_elig  = |elig;
    assign enq_ready = (count_q < CNT_W'(DEPTH)) && !flush_valid;
    assign deq_valid = any_elig && !flush_valid && !reset;
    assign deq_data  = any_elig ? ent_q[sel_idx].data  : '0;
    assign deq_robid = any_elig ? ent_q[sel_idx].robid : '0;
    assign deq_index = sel_idx;
    assign count     = count_q;
    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = deq_valid && deq_ready;

    always_comb begin
        valid_d = valid_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (flush_valid && valid_q[i] && younger(ent_q[i].robid, flush_robid)) begin
                valid_d[i] = 1'b0;
            end
        end
        if (deq_fire) begin
            valid_d[sel_idx] = 1'b0;
        end
        if (enq_fire) begin
            valid_d[free_idx] = 1'b1;
        end
        count_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            count_d = count_d + CNT_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
                rdy_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rdy_q[i] <= rdy_q[i] | wake[i];
            end
            // New entry is younger than everything currently resident.
            if (enq_fire) begin
                ent_q[free_idx] <= ent_t'{data: enq_data, robid: enq_robid,
                                          prs1: enq_prs1, prs2: enq_prs2};
                rdy_q[free_idx] <= enq_src_rdy | enq_wake;
                age_q[free_idx] <= '0;
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    if (valid_q[j]) begin
                        age_q[j][free_idx] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_int_isq_agemat.sv
// Bench for int_isq_agemat: directed scenarios plus a randomized run against an enqueue-order reference model.
module tb_int_isq_agemat;

    localparam int DEPTH   = 8;
    localparam int DATA_W  = 128;
    localparam int PREG_W  = 6;
    localparam int ROBID_W = 6;
    localparam int NUM_WB  = 2;

    logic                     clock;
    logic                     reset;
    logic                     enq_valid;
    logic                     enq_ready;
    logic [DATA_W-1:0]        enq_data;
    logic [PREG_W-1:0]        enq_prs1;
    logic [PREG_W-1:0]        enq_prs2;
    logic [1:0]               enq_src_rdy;
    logic [ROBID_W:0]         enq_robid;
    logic                     deq_valid;
    logic                     deq_ready;
    logic [DATA_W-1:0]        deq_data;
    logic [ROBID_W:0]         deq_robid;
    logic [2:0]               deq_index;
    logic [NUM_WB-1:0]        wb_valid;
    logic [NUM_WB*PREG_W-1:0] wb_prd;
    logic                     flush_valid;
    logic [ROBID_W:0]         flush_robid;
    logic [3:0]               count;

    int checks   = 0;
    int failures = 0;

    int_isq_agemat #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .PREG_W(PREG_W), .ROBID_W(ROBID_W), .NUM_WB(NUM_WB)
    ) dut (
        .clock(clock), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
        .enq_prs1(enq_prs1), .enq_prs2(enq_prs2), .enq_src_rdy(enq_src_rdy), .enq_robid(enq_robid),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
        .deq_robid(deq_robid), .deq_index(deq_index),
        .wb_valid(wb_valid), .wb_prd(wb_prd),
        .flush_valid(flush_valid), .flush_robid(flush_robid), .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: slots hold entries tagged with an enqueue sequence number; oldest = smallest seq.
    typedef struct {
        bit           v;
        bit [127:0]   data;
        bit [6:0]     robid;
        bit [5:0]     p1;
        bit [5:0]     p2;
        bit [1:0]     rdy;
        int unsigned  seq;
    } ment_t;

    ment_t       m [DEPTH];
    int unsigned seq_ctr = 0;
    int          m_cnt;
    int          m_idx;
    bit          m_any;
    bit          m_dv;
    bit          m_er;

    function automatic bit wb_hits(input bit [5:0] p);
        for (int q = 0; q < NUM_WB; q++) begin
            if (wb_valid[q] && (wb_prd[q*PREG_W +: PREG_W] == p)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit younger(input bit [6:0] a, input bit [6:0] b);
        if (a[6] != b[6]) return a[5:0] < b[5:0];
        return a[5:0] > b[5:0];
    endfunction

    task automatic model_eval();
        int unsigned best;
        bit [1:0]    r;
        m_cnt = 0;
        m_any = 1'b0;
        m_idx = 0;
        best  = 32'hFFFF_FFFF;
        for (int i = 0; i < DEPTH; i++) begin
            if (m[i].v) begin
                m_cnt++;
                r = m[i].rdy;
`ifdef ISQ_WB_BYPASS_EN
                r = r | {wb_hits(m[i].p1), wb_hits(m[i].p2)};
`endif
                if (r == 2'b11 && m[i].seq < best) begin
                    best  = m[i].seq;
                    m_idx = i;
                    m_any = 1'b1;
                end
            end
        end
        m_dv = m_any && !flush_valid && !reset;
        m_er = (m_cnt < DEPTH) && !flush_valid;
    endtask

    task automatic model_step();
        int fs;
        bit efire;
        bit dfire;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
            return;
        end
        efire = enq_valid && m_er;
        dfire = m_dv && deq_ready;
        fs = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (!m[i].v && fs < 0) fs = i;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (m[i].v) begin
                m[i].rdy = m[i].rdy | {wb_hits(m[i].p1), wb_hits(m[i].p2)};
                if (flush_valid && younger(m[i].robid, flush_robid)) m[i].v = 1'b0;
            end
        end
        if (dfire) m[m_idx].v = 1'b0;
        if (efire && fs >= 0) begin
            m[fs] = '{v: 1'b1, data: enq_data, robid: enq_robid, p1: enq_prs1, p2: enq_prs2,
                      rdy: enq_src_rdy | {wb_hits(enq_prs1), wb_hits(enq_prs2)}, seq: seq_ctr};
            seq_ctr++;
        end
    endtask

    task automatic idle();
        enq_valid   = 1'b0;
        enq_data    = '0;
        enq_prs1    = '0;
        enq_prs2    = '0;
        enq_src_rdy = 2'b00;
        enq_robid   = '0;
        deq_ready   = 1'b0;
        wb_valid    = '0;
        wb_prd      = '0;
        flush_valid = 1'b0;
        flush_robid = '0;
    endtask

    task automatic settle();
        @(negedge clock);
        model_eval();
    endtask

    task automatic adv();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_enq(input bit [127:0] d, input bit [6:0] rid, input bit [5:0] p1,
                           input bit [5:0] p2, input bit [1:0] rdy);
        enq_valid   = 1'b1;
        enq_data    = d;
        enq_robid   = rid;
        enq_prs1    = p1;
        enq_prs2    = p2;
        enq_src_rdy = rdy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        settle();
        adv();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        checks++;
        if ({deq_valid, enq_ready, count, deq_index} !== {1'b0, 1'b1, 4'd0, 3'd0}) begin
            failures++;
            $display("FAIL reset_ctl: got dv=%b er=%b cnt=%0d idx=%0d, want 0/1/0/0",
                     deq_valid, enq_ready, count, deq_index);
        end
        checks++;
        if ({deq_data, deq_robid} !== '0) begin
            failures++;
            $display("FAIL reset_payload: got data=%h robid=%h, want 0", deq_data, deq_robid);
        end
        adv();
    endtask

    task automatic test_inorder();
        bit [6:0] issued [$];
        do_reset();
        for (int c = 0; c < 6; c++) begin
            idle();
            deq_ready = 1'b1;
            if (c < 3) set_enq({$urandom, $urandom, $urandom, $urandom}, 7'(c + 1),
                               6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 2'b11);
            settle();
            checks++;
            if ({deq_valid, enq_ready, count} !== {m_dv, m_er, 4'(m_cnt)}) begin
                failures++;
                $display("FAIL inorder_ctl c%0d: got dv=%b er=%b cnt=%0d, want %b/%b/%0d",
                         c, deq_valid, enq_ready, count, m_dv, m_er, m_cnt);
            end
            if (m_dv) begin
                checks++;
                if ({deq_data, deq_robid, deq_index} !== {m[m_idx].data, m[m_idx].robid, 3'(m_idx)}) begin
                    failures++;
                    $display("FAIL inorder_sel c%0d: got robid=%h idx=%0d, want robid=%h idx=%0d",
                             c, deq_robid, deq_index, m[m_idx].robid, m_idx);
                end
            end
            if (deq_valid && deq_ready) issued.push_back(deq_robid);
            adv();
        end
        settle();
        checks++;
        if (issued.size() != 3 || issued[0] != 7'd1 || issued[1] != 7'd2 || issued[2] != 7'd3 || count != 4'd0) begin
            failures++;
            $display("FAIL inorder_order: got %0d issues cnt=%0d, want 3 issues (1,2,3) cnt=0",
                     issued.size(), count);
        end
        adv();
    endtask

    task automatic test_wakeup();
        bit [6:0] issued [$];
        int       first_cyc;
        first_cyc = -1;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            idle();
            deq_ready = 1'b1;
            if (c == 0) set_enq(128'hA, 7'd10, 6'd5, 6'd7, 2'b01);
            if (c == 1) set_enq(128'hB, 7'd11, 6'd1, 6'd2, 2'b11);
            if (c == 2) begin
                wb_valid = 2'b01;
                wb_prd   = {6'd0, 6'd5};
            end
            settle();
            checks++;
            if ({deq_valid, enq_ready, count} !== {m_dv, m_er, 4'(m_cnt)}) begin
                failures++;
                $display("FAIL wakeup_ctl c%0d: got dv=%b er=%b cnt=%0d, want %b/%b/%0d",
                         c, deq_valid, enq_ready, count, m_dv, m_er, m_cnt);
            end
            if (deq_valid && deq_ready) begin
                if (first_cyc < 0) first_cyc = c;
                issued.push_back(deq_robid);
            end
            adv();
        end
        checks++;
`ifdef ISQ_WB_BYPASS_EN
        if (issued.size() != 2 || issued[0] != 7'd10 || issued[1] != 7'd11 || first_cyc != 2) begin
            failures++;
            $display("FAIL wakeup_order: got n=%0d first=%h@c%0d, want A(0a) then B(0b) from c2",
                     issued.size(), issued.size() > 0 ? issued[0] : 7'd0, first_cyc);
        end
`else
        if (issued.size() != 2 || issued[0] != 7'd11 || issued[1] != 7'd10 || first_cyc != 2) begin
            failures++;
            $display("FAIL wakeup_order: got n=%0d first=%h@c%0d, want B(0b) then A(0a) from c2",
                     issued.size(), issued.size() > 0 ? issued[0] : 7'd0, first_cyc);
        end
`endif
    endtask

    task automatic test_full();
        do_reset();
        for (int c = 0; c < DEPTH; c++) begin
            idle();
            set_enq({$urandom, $urandom, $urandom, $urandom}, 7'(c), 6'(c), 6'(c + 8), 2'b11);
            settle();
            checks++;
            if ({deq_valid, enq_ready, count} !== {m_dv, m_er, 4'(m_cnt)}) begin
                failures++;
                $display("FAIL full_fill c%0d: got dv=%b er=%b cnt=%0d, want %b/%b/%0d",
                         c, deq_valid, enq_ready, count, m_dv, m_er, m_cnt);
            end
            adv();
        end
        idle();
        settle();
        checks++;
        if ({enq_ready, count} !== {1'b0, 4'd8}) begin
            failures++;
            $display("FAIL full_stop: got er=%b cnt=%0d, want er=0 cnt=8", enq_ready, count);
        end
        adv();
        idle();
        set_enq(128'hFEED, 7'd20, 6'd1, 6'd1, 2'b11);
        deq_ready = 1'b1;
        settle();
        checks++;
        if ({enq_ready, deq_valid, deq_index, deq_robid} !== {1'b0, 1'b1, 3'd0, 7'd0}) begin
            failures++;
            $display("FAIL full_encdeq: got er=%b dv=%b idx=%0d robid=%h, want 0/1/0/00",
                     enq_ready, deq_valid, deq_index, deq_robid);
        end
        adv();
        idle();
        settle();
        checks++;
        if (count !== 4'd7 || count !== 4'(m_cnt)) begin
            failures++;
            $display("FAIL full_after: got cnt=%0d, want 7", count);
        end
        adv();
    endtask

    task automatic test_flush();
        bit [6:0] rids [4];
        rids = '{7'h3E, 7'h3F, 7'h40, 7'h41};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            idle();
            set_enq(128'(c + 100), rids[c], 6'd3, 6'd4, 2'b11);
            settle();
            adv();
        end
        idle();
        flush_valid = 1'b1;
        flush_robid = 7'h3F;
        deq_ready   = 1'b1;
        set_enq(128'h55, 7'h42, 6'd0, 6'd0, 2'b11);
        settle();
        checks++;
        if ({deq_valid, enq_ready, count} !== {1'b0, 1'b0, 4'd4}) begin
            failures++;
            $display("FAIL flush_cycle: got dv=%b er=%b cnt=%0d, want 0/0/4", deq_valid, enq_ready, count);
        end
        adv();
        idle();
        settle();
        checks++;
        if ({count, deq_valid, deq_robid} !== {4'd2, 1'b1, 7'h3E} || count !== 4'(m_cnt)) begin
            failures++;
            $display("FAIL flush_after: got cnt=%0d dv=%b robid=%h, want cnt=2 dv=1 robid=3e",
                     count, deq_valid, deq_robid);
        end
        adv();
    endtask

    task automatic test_dual_wb();
        do_reset();
        idle();
        set_enq(128'hC0DE, 7'd1, 6'd9, 6'd9, 2'b00);
        settle();
        adv();
        idle();
        wb_valid = 2'b11;
        wb_prd   = {6'd9, 6'd9};
        set_enq(128'hBEEF, 7'd2, 6'd9, 6'd3, 2'b01);
        settle();
        checks++;
        if ({deq_valid, enq_ready} !== {m_dv, m_er}) begin
            failures++;
            $display("FAIL dualwb_hit: got dv=%b er=%b, want %b/%b", deq_valid, enq_ready, m_dv, m_er);
        end
        adv();
        for (int c = 0; c < 2; c++) begin
            idle();
            deq_ready = 1'b1;
            settle();
            checks++;
            if ({deq_valid, deq_robid} !== {1'b1, 7'(c + 1)}) begin
                failures++;
                $display("FAIL dualwb_issue c%0d: got dv=%b robid=%h, want dv=1 robid=%0d",
                         c, deq_valid, deq_robid, c + 1);
            end
            adv();
        end
        idle();
        settle();
        checks++;
        if ({deq_valid, count} !== {1'b0, 4'd0}) begin
            failures++;
            $display("FAIL dualwb_drain: got dv=%b cnt=%0d, want 0/0", deq_valid, count);
        end
        adv();
    endtask

    task automatic test_stall();
        bit [127:0] sdata;
        sdata = {$urandom, $urandom, $urandom, $urandom};
        do_reset();
        idle();
        set_enq(sdata, 7'd5, 6'd11, 6'd12, 2'b11);
        settle();
        adv();
        for (int c = 0; c < 4; c++) begin
            idle();
            settle();
            checks++;
            if ({deq_valid, deq_data, deq_index, deq_robid} !== {1'b1, sdata, 3'd0, 7'd5}) begin
                failures++;
                $display("FAIL stall_hold c%0d: got dv=%b idx=%0d data=%h, want dv=1 idx=0 data=%h",
                         c, deq_valid, deq_index, deq_data, sdata);
            end
            adv();
        end
        idle();
        reset     = 1'b1;
        deq_ready = 1'b1;
        settle();
        checks++;
        if (deq_valid !== m_dv) begin
            failures++;
            $display("FAIL stall_rstcyc: got dv=%b, want %b", deq_valid, m_dv);
        end
        adv();
        reset = 1'b0;
        idle();
        settle();
        checks++;
        if ({deq_valid, count, enq_ready} !== {1'b0, 4'd0, 1'b1}) begin
            failures++;
            $display("FAIL stall_rst: got dv=%b cnt=%0d er=%b, want 0/0/1", deq_valid, count, enq_ready);
        end
        adv();
    endtask

    task automatic test_random();
        bit [6:0] rob_ctr;
        int       k;
        rob_ctr = 7'h30;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            idle();
            enq_valid   = ($urandom_range(0, 99) < 60);
            enq_data    = {$urandom, $urandom, $urandom, $urandom};
            enq_prs1    = 6'($urandom_range(0, 7));
            enq_prs2    = 6'($urandom_range(0, 7));
            enq_src_rdy = 2'($urandom_range(0, 3));
            enq_robid   = rob_ctr;
            deq_ready   = ($urandom_range(0, 99) < 50);
            wb_valid    = 2'($urandom_range(0, 3));
            wb_prd      = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
            if ($urandom_range(0, 99) < 5) begin
                k = $urandom_range(0, DEPTH - 1);
                flush_valid = 1'b1;
                flush_robid = m[k].v ? m[k].robid : 7'(rob_ctr - 7'd1);
            end
            settle();
            checks++;
            if ({deq_valid, enq_ready, count} !== {m_dv, m_er, 4'(m_cnt)}) begin
                failures++;
                $display("FAIL random_ctl c%0d: got dv=%b er=%b cnt=%0d, want %b/%b/%0d",
                         c, deq_valid, enq_ready, count, m_dv, m_er, m_cnt);
            end
            if (m_dv) begin
                checks++;
                if ({deq_data, deq_robid, deq_index} !== {m[m_idx].data, m[m_idx].robid, 3'(m_idx)}) begin
                    failures++;
                    $display("FAIL random_sel c%0d: got robid=%h idx=%0d, want robid=%h idx=%0d",
                             c, deq_robid, deq_index, m[m_idx].robid, m_idx);
                end
            end
            if (flush_valid) rob_ctr = flush_robid + 7'd1;
            else if (enq_valid && m_er) rob_ctr = rob_ctr + 7'd1;
            adv();
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_inorder();
        test_wakeup();
        test_full();
        test_flush();
        test_dual_wb();
        test_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
